// File: rtl/tc_pl_acp_pkg.sv
// Shared types and widths for the capture-path ACP transmit arbitration blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: default ACP bus widths, arbiter state enum, index-width helper.
package tc_pl_acp_pkg;

  localparam int ACP_ADDR_W = 32;
  localparam int ACP_ID_W   = 3;
  localparam int ACP_DATA_W = 64;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Width of an index into n slots; never below 1 so a 1- or 2-entry
  // table still gets a real bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tc_pl_rr_pick.sv
// Round-robin priority picker: first set request after rr_ptr, with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides when to consume the winner.
//
// Ports:
//   req     in  N     request vector
//   rr_ptr  in  IW    last winner; search starts at rr_ptr+1
//   vld     out 1     at least one request set
//   win     out IW    winning index (0 when vld is low)
module tc_pl_rr_pick
  import tc_pl_acp_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          vld,
  output logic [IW-1:0] win
);

  int idx;

  // Walk the offsets from farthest to nearest so the last hit, which is the
  // closest set bit after rr_ptr, is the one left in win.
  always_comb begin
    vld = 1'b0;
    win = '0;
    idx = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % N;
      if (req[idx]) begin
        vld = 1'b1;
        win = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/tc_pl_acp_tx_arb.sv
// Round-robin arbiter sharing one ACP write-transmit port among N_REQ requesters.
// Latency: 1 cycle from req_en to acp_tx_en; req_rdy / err_tmo registered, 1 cycle after port rdy / timeout.
// Backpressure: one burst at a time; others wait on level req_en; watchdog frees a hung grant.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   cfg_timeout      watchdog limit in BUSY cycles, 0 disables; captured at grant
//   req_en           per-requester burst request (level)
//   req_awaddr/awid  packed per-slot address / ID, slot i at [i*W +: W]
//   req_wdata        packed per-slot write data
//   req_wdreq        port data-request strobe steered to the grant holder
//   req_rdy          one-cycle burst-done pulse to the grant holder
//   acp_tx_*         shared port: en/awaddr/awid/wdata out, rdy/wdreq in
//   busy, grant_idx  grant held / current or last grant
//   err_tmo, err_idx watchdog abort pulse / aborted requester (held)
module tc_pl_acp_tx_arb
  import tc_pl_acp_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int ADDR_W = ACP_ADDR_W,
  parameter  int ID_W   = ACP_ID_W,
  parameter  int DATA_W = ACP_DATA_W,
  parameter  int TMO_W  = 16,
  localparam int IDX_W  = idx_w(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [TMO_W-1:0]         cfg_timeout,
  input  logic [N_REQ-1:0]         req_en,
  input  logic [N_REQ*ADDR_W-1:0]  req_awaddr,
  input  logic [N_REQ*ID_W-1:0]    req_awid,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_wdreq,
  output logic [N_REQ-1:0]         req_rdy,
  output logic                     acp_tx_en,
  input  logic                     acp_tx_rdy,
  output logic [ADDR_W-1:0]        acp_tx_awaddr,
  output logic [ID_W-1:0]          acp_tx_awid,
  output logic [DATA_W-1:0]        acp_tx_wdata,
  input  logic                     acp_tx_wdreq,
  output logic                     busy,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     err_tmo,
  output logic [IDX_W-1:0]         err_idx
);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_lim;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic             tmo_hit;

  tc_pl_rr_pick #(
    .N  (N_REQ),
    .IW (IDX_W)
  ) u_pick (
    .req    (req_en),
    .rr_ptr (rr_ptr),
    .vld    (pick_vld),
    .win    (pick_idx)
  );

  // Limit is the latched copy so a reprogram mid-burst only affects the
  // next grant. tmo_cnt is 0 in the first BUSY cycle, so matching limit-1
  // aborts at the end of BUSY cycle number tmo_lim.
  assign tmo_hit = (state == ARB_BUSY) && (tmo_lim != '0) &&
                   (tmo_cnt == (tmo_lim - TMO_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB_IDLE;
      rr_ptr        <= IDX_W'(N_REQ - 1);
      grant_idx     <= '0;
      acp_tx_awaddr <= '0;
      acp_tx_awid   <= '0;
      tmo_cnt       <= '0;
      tmo_lim       <= '0;
      req_rdy       <= '0;
      err_tmo       <= 1'b0;
      err_idx       <= '0;
    end else begin
      req_rdy <= '0;
      err_tmo <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            grant_idx     <= pick_idx;
            acp_tx_awaddr <= req_awaddr[int'(pick_idx)*ADDR_W +: ADDR_W];
            acp_tx_awid   <= req_awid[int'(pick_idx)*ID_W +: ID_W];
            rr_ptr        <= pick_idx;
            tmo_cnt       <= '0;
            tmo_lim       <= cfg_timeout;
            state         <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          // Port completion beats the watchdog when both land together.
          if (acp_tx_rdy) begin
            req_rdy[grant_idx] <= 1'b1;
            state              <= ARB_IDLE;
          end else if (tmo_hit) begin
            err_tmo <= 1'b1;
            err_idx <= grant_idx;
            state   <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Port enable and busy come straight off the state flop; leaving BUSY
  // always passes through one IDLE cycle, which gives the inter-burst gap.
  assign acp_tx_en = (state == ARB_BUSY);
  assign busy      = (state == ARB_BUSY);

  // Steering is gated by BUSY so stray port strobes while idle go nowhere
  // and the shared data bus reads 0 when nobody owns it.
  always_comb begin
    req_wdreq    = '0;
    acp_tx_wdata = '0;
    if (state == ARB_BUSY) begin
      req_wdreq[grant_idx] = acp_tx_wdreq;
      acp_tx_wdata         = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
    end
  end

  a_wdreq_onehot : assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_wdreq));
  a_rdy_onehot : assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_rdy));
  a_rdy_xor_err : assert property (@(posedge clk) disable iff (rst)
    !((req_rdy != '0) && err_tmo));

endmodule

// File: tb/tb_tc_pl_acp_tx_arb.sv
module tb_tc_pl_acp_tx_arb;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int IW = 3;
  localparam int DW = 64;
  localparam int TW = 16;
  localparam int XW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [TW-1:0]   cfg_timeout = '0;
  logic [N-1:0]    req_en = '0;
  logic [N*AW-1:0] req_awaddr;
  logic [N*IW-1:0] req_awid;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_wdreq;
  logic [N-1:0]    req_rdy;
  logic            acp_tx_en;
  logic            acp_tx_rdy = 1'b0;
  logic [AW-1:0]   acp_tx_awaddr;
  logic [IW-1:0]   acp_tx_awid;
  logic [DW-1:0]   acp_tx_wdata;
  logic            acp_tx_wdreq = 1'b0;
  logic            busy;
  logic [XW-1:0]   grant_idx;
  logic            err_tmo;
  logic [XW-1:0]   err_idx;

  logic [AW-1:0] slot_addr [N];
  logic [IW-1:0] slot_id   [N];
  logic [DW-1:0] slot_data [N];

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_awaddr[i*AW +: AW] = slot_addr[i];
      req_awid[i*IW +: IW]   = slot_id[i];
      req_wdata[i*DW +: DW]  = slot_data[i];
    end
  end

  tc_pl_acp_tx_arb #(
    .N_REQ (N), .ADDR_W (AW), .ID_W (IW), .DATA_W (DW), .TMO_W (TW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_timeout   (cfg_timeout),
    .req_en        (req_en),
    .req_awaddr    (req_awaddr),
    .req_awid      (req_awid),
    .req_wdata     (req_wdata),
    .req_wdreq     (req_wdreq),
    .req_rdy       (req_rdy),
    .acp_tx_en     (acp_tx_en),
    .acp_tx_rdy    (acp_tx_rdy),
    .acp_tx_awaddr (acp_tx_awaddr),
    .acp_tx_awid   (acp_tx_awid),
    .acp_tx_wdata  (acp_tx_wdata),
    .acp_tx_wdreq  (acp_tx_wdreq),
    .busy          (busy),
    .grant_idx     (grant_idx),
    .err_tmo       (err_tmo),
    .err_idx       (err_idx)
  );

  task automatic apply_reset();
    rst = 1'b1; req_en = '0; acp_tx_rdy = 1'b0; acp_tx_wdreq = 1'b0; cfg_timeout = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Waits (bounded) for acp_tx_en at negedges; cyc = negedges consumed.
  task automatic wait_en(output int cyc);
    cyc = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      cyc = c;
      if (acp_tx_en) break;
    end
    if (!acp_tx_en) begin
      n_cmp++; n_err++;
      $display("FAIL wait_en: acp_tx_en=0 after %0d cycles, required 1", cyc);
    end
  endtask

  // Pops the expected winner and checks the grant sampled at this negedge.
  task automatic check_grant(output int e);
    e = 0;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL grant_sb: grant %0d with empty scoreboard", grant_idx);
    end else begin
      e = exp_q.pop_front();
      if (grant_idx !== XW'(e)) begin
        n_err++; $display("FAIL grant_idx: got %0d, required %0d", grant_idx, e);
      end
    end
    n_cmp++;
    if (acp_tx_awaddr !== slot_addr[e]) begin
      n_err++; $display("FAIL awaddr: got %h, required %h", acp_tx_awaddr, slot_addr[e]);
    end
    n_cmp++;
    if (acp_tx_awid !== slot_id[e]) begin
      n_err++; $display("FAIL awid: got %0d, required %0d", acp_tx_awid, slot_id[e]);
    end
  endtask

  // Entered at the negedge where acp_tx_en was first seen high; runs nstr
  // data strobes then a port rdy, leaving at the IDLE-entry negedge.
  task automatic do_burst(input int nstr);
    int e;
    check_grant(e);
    for (int s = 0; s < nstr; s++) begin
      @(posedge clk); #1;
      acp_tx_wdreq = 1'b1;
      for (int i = 0; i < N; i++) slot_data[i] = {$urandom(), $urandom()};
      @(negedge clk);
      n_cmp++;
      if (req_wdreq !== N'(1 << e)) begin
        n_err++; $display("FAIL wdreq_route: got %b, required %b", req_wdreq, N'(1 << e));
      end
      n_cmp++;
      if (acp_tx_wdata !== slot_data[e]) begin
        n_err++; $display("FAIL wdata_mux: got %h, required %h", acp_tx_wdata, slot_data[e]);
      end
    end
    @(posedge clk); #1;
    acp_tx_wdreq = 1'b0; acp_tx_rdy = 1'b1;
    @(posedge clk); #1;
    acp_tx_rdy = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_rdy !== N'(1 << e)) begin
      n_err++; $display("FAIL req_rdy: got %b, required %b", req_rdy, N'(1 << e));
    end
    n_cmp++;
    if ({acp_tx_en, busy, err_tmo} !== 3'b000) begin
      n_err++; $display("FAIL burst_end: en/busy/err got %b, required 000", {acp_tx_en, busy, err_tmo});
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_cmp++;
    if ({acp_tx_en, busy, grant_idx, req_rdy, req_wdreq, err_tmo, err_idx} !== '0) begin
      n_err++; $display("FAIL reset_ctrl: got %b, required 0",
                        {acp_tx_en, busy, grant_idx, req_rdy, req_wdreq, err_tmo, err_idx});
    end
    n_cmp++;
    if ({acp_tx_awaddr, acp_tx_awid, acp_tx_wdata} !== '0) begin
      n_err++; $display("FAIL reset_bus: got %h, required 0", {acp_tx_awaddr, acp_tx_awid, acp_tx_wdata});
    end
  endtask

  task automatic test_single();
    apply_reset();
    @(posedge clk); #1;
    req_en = 4'b0001;
    exp_q.push_back(0);
    @(negedge clk);
    n_cmp++;
    if (acp_tx_en !== 1'b0) begin
      n_err++; $display("FAIL en_latency0: got %b, required 0", acp_tx_en);
    end
    @(negedge clk);
    n_cmp++;
    if (acp_tx_en !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL en_latency1: en/busy got %b%b, required 11", acp_tx_en, busy);
    end
    req_en = '0;
    do_burst(8);
    // Port strobes while idle must not reach anyone.
    @(posedge clk); #1;
    acp_tx_wdreq = 1'b1; acp_tx_rdy = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_wdreq !== '0 || acp_tx_wdata !== '0) begin
      n_err++; $display("FAIL idle_wdreq: wdreq %b wdata %h, required 0", req_wdreq, acp_tx_wdata);
    end
    @(posedge clk); #1;
    acp_tx_wdreq = 1'b0; acp_tx_rdy = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_rdy !== '0 || acp_tx_en !== 1'b0) begin
      n_err++; $display("FAIL idle_rdy: req_rdy %b en %b, required 0", req_rdy, acp_tx_en);
    end
  endtask

  task automatic run_held(input logic [N-1:0] pattern, input int nb);
    int cyc;
    @(posedge clk); #1;
    req_en = pattern;
    for (int i = 0; i < nb; i++) begin
      wait_en(cyc);
      if (i > 0) begin
        n_cmp++;
        if (cyc !== 1) begin
          n_err++; $display("FAIL idle_gap: burst %0d after %0d cycles, required 1", i, cyc);
        end
      end
      do_burst(2);
    end
    req_en = '0;
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < 8; i++) exp_q.push_back(i % 4);
    run_held(4'b1111, 8);
  endtask

  task automatic test_fairness();
    apply_reset();
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(2);
    run_held(4'b0101, 4);
  endtask

  task automatic test_watchdog();
    int cyc, e, bcyc;
    apply_reset();
    cfg_timeout = 16'd20;
    exp_q.push_back(0); exp_q.push_back(1);
    @(posedge clk); #1;
    req_en = 4'b0011;
    for (int b = 0; b < 2; b++) begin
      wait_en(cyc);
      if (b == 1) begin
        n_cmp++;
        if (cyc !== 1 || err_tmo !== 1'b0 || err_idx !== 2'd0) begin
          n_err++; $display("FAIL tmo_next: gap %0d err_tmo %b err_idx %0d, required 1 0 0", cyc, err_tmo, err_idx);
        end
        // Mid-burst reprogram must not shorten this burst.
        cfg_timeout = 16'd5;
        req_en = '0;
      end
      check_grant(e);
      bcyc = 1;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (err_tmo) break;
        if (acp_tx_en) bcyc++;
      end
      n_cmp++;
      if (err_tmo !== 1'b1 || bcyc !== 20) begin
        n_err++; $display("FAIL tmo_pulse: err_tmo %b after %0d busy cycles, required 1 after 20", err_tmo, bcyc);
      end
      n_cmp++;
      if (err_idx !== XW'(e) || req_rdy !== '0 || acp_tx_en !== 1'b0) begin
        n_err++; $display("FAIL tmo_abort: err_idx %0d req_rdy %b en %b, required %0d 0000 0", err_idx, req_rdy, acp_tx_en, e);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (err_tmo !== 1'b0 || err_idx !== 2'd1) begin
      n_err++; $display("FAIL tmo_hold: err_tmo %b err_idx %0d, required 0 1", err_tmo, err_idx);
    end
  endtask

  task automatic test_race();
    int cyc, e, errs, drops;
    apply_reset();
    cfg_timeout = 16'd20;
    exp_q.push_back(0);
    @(posedge clk); #1;
    req_en = 4'b0001;
    wait_en(cyc);
    req_en = '0;
    check_grant(e);
    repeat (19) @(posedge clk);
    #1 acp_tx_rdy = 1'b1;
    @(posedge clk); #1;
    acp_tx_rdy = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_rdy !== 4'b0001 || err_tmo !== 1'b0) begin
      n_err++; $display("FAIL race: req_rdy %b err_tmo %b, required 0001 0", req_rdy, err_tmo);
    end
    // Disabled watchdog: hold a burst past the counter wrap.
    cfg_timeout = '0;
    exp_q.push_back(1);
    @(posedge clk); #1;
    req_en = 4'b0010;
    wait_en(cyc);
    req_en = '0;
    check_grant(e);
    errs = 0; drops = 0;
    repeat (70000) begin
      @(negedge clk);
      if (err_tmo) errs++;
      if (!acp_tx_en) drops++;
    end
    n_cmp++;
    if (errs !== 0 || drops !== 0) begin
      n_err++; $display("FAIL tmo_disabled: %0d aborts %0d drops, required 0 0", errs, drops);
    end
    @(posedge clk); #1;
    acp_tx_rdy = 1'b1;
    @(posedge clk); #1;
    acp_tx_rdy = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_rdy !== 4'b0010) begin
      n_err++; $display("FAIL tmo_disabled_rdy: got %b, required 0010", req_rdy);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, e;
    apply_reset();
    cfg_timeout = 16'd4;
    exp_q.push_back(2); exp_q.push_back(2);
    @(posedge clk); #1;
    req_en = 4'b0100;
    wait_en(cyc);
    check_grant(e);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (err_tmo) break;
    end
    n_cmp++;
    if (err_tmo !== 1'b1 || err_idx !== 2'd2) begin
      n_err++; $display("FAIL pre_rst_tmo: err_tmo %b err_idx %0d, required 1 2", err_tmo, err_idx);
    end
    wait_en(cyc);
    check_grant(e);
    @(posedge clk); #1;
    acp_tx_wdreq = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req_en = 4'b1111;
    @(negedge clk);
    n_cmp++;
    if ({acp_tx_en, busy, grant_idx, req_rdy, req_wdreq, err_tmo, err_idx} !== '0) begin
      n_err++; $display("FAIL rst_mid_ctrl: got %b, required 0",
                        {acp_tx_en, busy, grant_idx, req_rdy, req_wdreq, err_tmo, err_idx});
    end
    n_cmp++;
    if ({acp_tx_awaddr, acp_tx_awid, acp_tx_wdata} !== '0) begin
      n_err++; $display("FAIL rst_mid_bus: got %h, required 0", {acp_tx_awaddr, acp_tx_awid, acp_tx_wdata});
    end
    acp_tx_wdreq = 1'b0;
    exp_q.push_back(0);
    wait_en(cyc);
    n_cmp++;
    if (cyc !== 1) begin
      n_err++; $display("FAIL rst_regrant_lat: got %0d cycles, required 1", cyc);
    end
    check_grant(e);
    req_en = '0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      slot_addr[i] = 32'h1000_0000 + 32'(i) * 32'h100;
      slot_id[i]   = IW'(i + 1);
      slot_data[i] = {32'hD0D0_0000 | 32'(i), 32'h0};
    end
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_watchdog();
    test_race();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: bench still running at %0t, required finish", $time);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/tc_pl_acp_tx_arb.md
Name: tc_pl_acp_tx_arb

Overview:
- Round-robin arbiter sharing one ACP0 write-transmit port between N_REQ capture-data requesters (acp tx engines of parallel capture channels).
- Grants one requester per burst and forwards its address/ID to the port.
- Steers the port's data-request strobes to the grant holder and muxes its write data back.
- Per-burst watchdog releases a hung grant and reports which requester hung.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 32, awaddr width
ID_W, 3, awid width
DATA_W, 64, wdata width
TMO_W, 16, watchdog counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cfg_timeout  in  TMO_W  watchdog limit in cycles; 0 = disabled
req_en  in  N_REQ  per-requester burst request, level
req_awaddr  in  N_REQ*ADDR_W  packed addresses, slot i at [i*ADDR_W +: ADDR_W]
req_awid  in  N_REQ*ID_W  packed IDs
req_wdata  in  N_REQ*DATA_W  packed write data
req_wdreq  out  N_REQ  data-request strobe routed to the grant holder
req_rdy  out  N_REQ  one-cycle burst-done pulse to the grant holder
acp_tx_en  out  1  burst request to port
acp_tx_rdy  in  1  one-cycle burst-done pulse from port
acp_tx_awaddr  out  ADDR_W  registered address
acp_tx_awid  out  ID_W  registered ID
acp_tx_wdata  out  DATA_W  write data from the grant holder
acp_tx_wdreq  in  1  data-request strobe from port
busy  out  1  grant held
grant_idx  out  clog2(N_REQ)  current or last grant
err_tmo  out  1  one-cycle watchdog-abort pulse
err_idx  out  clog2(N_REQ)  requester aborted, held until next abort

Behaviour:
- Reset: state IDLE; all outputs 0; rr_ptr = N_REQ-1, so requester 0 has first priority.
- IDLE, any req_en set:
  - Winner = first set bit searching rr_ptr+1, rr_ptr+2 ... with wrap.
  - Register grant_idx, acp_tx_awaddr and acp_tx_awid from the winner's slot.
  - rr_ptr <= winner; tmo_cnt <= 0; go BUSY.
  - acp_tx_en = 1 from the next cycle (1-cycle request-to-enable latency).
- BUSY:
  - acp_tx_en = 1 and busy = 1.
  - awaddr and awid held constant.
  - req_wdreq[grant_idx] = acp_tx_wdreq combinationally; other bits 0.
  - acp_tx_wdata = req_wdata slot grant_idx, combinational mux.
- BUSY exit on acp_tx_rdy:
  - req_rdy[grant_idx] pulses 1 cycle, registered, coincident with the IDLE entry cycle.
  - acp_tx_en drops to 0; go IDLE.
  - Minimum one IDLE cycle between bursts; acp_tx_en is never high for two requesters back-to-back.
- Watchdog: tmo_cnt increments each BUSY cycle.
  - If cfg_timeout != 0 and tmo_cnt == cfg_timeout-1 with no acp_tx_rdy: pulse err_tmo and set err_idx = grant_idx.
  - Go IDLE with no req_rdy pulse.
  - acp_tx_rdy in the same cycle wins: normal completion, no error.
- cfg_timeout is sampled at grant; changes mid-burst do not affect the current burst.
- req_en deasserting during BUSY is ignored; the grant is held until rdy or timeout.
- A requester holding req_en after req_rdy re-enters arbitration but yields to other active requesters (fairness).
- acp_tx_rdy or acp_tx_wdreq outside BUSY: ignored, not forwarded.
- Single requester continuously active: re-granted every burst, with a 1-cycle IDLE gap between bursts.
- rst mid-burst: immediate return to IDLE, outputs 0, no req_rdy or err pulse. The port is expected to be reset by the same rst.

Decomposition:
- Shared package tc_pl_acp_pkg holds:
  - ACP_ADDR_W = 32, ACP_ID_W = 3, ACP_DATA_W = 64.
  - State enum {ARB_IDLE, ARB_BUSY}.
  - An idx-width function (clog2).
- Sub-module tc_pl_rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: valid, winner index.
  - Reused by later capture-trigger arbiters.

Test Plan:
- Single requester: req_en=4'b0001, awaddr0=0x1000_0000, awid0=1. Required: acp_tx_en rises 1 cycle later, awaddr=0x1000_0000, awid=1; 8 wdreq strobes reach req_wdreq[0] only, wdata follows slot 0; rdy gives req_rdy=4'b0001 pulse and acp_tx_en low.
- Round robin: req_en=4'b1111 held for 8 bursts. Required: grant order 0,1,2,3,0,1,2,3; one IDLE cycle between bursts.
- Fairness: req_en=4'b0101 with requester 0 re-requesting immediately. Required: grants alternate 0,2,0,2.
- Watchdog: cfg_timeout=20, no acp_tx_rdy. Required: err_tmo pulses on cycle 20 of BUSY, err_idx=granted idx, no req_rdy, next requester granted.
- Race: acp_tx_rdy on the exact timeout cycle. Required: req_rdy pulse, err_tmo stays 0. With cfg_timeout=0: no abort after 70000 cycles.
- Reset mid-burst: rst for 1 cycle during BUSY. Required: all outputs 0 next cycle; first grant after reset goes to requester 0.
